// File: rtl/oram_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : oram_ram_arbiter_if
// Brief   : Bundle of the two requester ports and the shared ExampleRAM port
//           handled by oram_ram_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface oram_ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // Requester A (ORAM Handler) and requester B (secondary memory client)
  logic              req_a;
  logic              req_b;
  logic              rw_a;
  logic              rw_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              lock_a;
  logic              ack_a;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              busy;

  // Shared RAM port
  logic [ADDR_W-1:0] ram_address;
  logic [ADDR_W-1:0] ram_raddress;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic              ram_re;
  logic              ram_oe;

  // Arbiter side
  modport slave (
    input  req_a, req_b, rw_a, rw_b, addr_a, addr_b, wdata_a, wdata_b, lock_a,
    output ack_a, ack_b, rdata_a, rdata_b, busy,
    output ram_address, ram_raddress, ram_wdata, ram_we, ram_re, ram_oe,
    input  ram_rdata
  );

  // Requesters plus RAM side
  modport master (
    output req_a, req_b, rw_a, rw_b, addr_a, addr_b, wdata_a, wdata_b, lock_a,
    input  ack_a, ack_b, rdata_a, rdata_b, busy,
    input  ram_address, ram_raddress, ram_wdata, ram_we, ram_re, ram_oe,
    output ram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/oram_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : oram_ram_arbiter
// Brief   : Round-robin arbiter/sequencer serialising two requesters onto one
//           ExampleRAM port, with an optional exclusive lock for requester A.
// Revision: 1.0 - initial release
// ============================================================================
module oram_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  oram_ram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] c_rd_lat  = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              win_b_q, win_b_d;     // current winner: 0 = A, 1 = B
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_b_q, last_b_d;   // last grant went to B
  logic              lock_q, lock_d;       // A holds exclusive ownership
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

  logic              w_grant;
  logic              w_pick_b;

  // Arbitration decision, only consumed while IDLE
  always_comb begin
    w_grant  = 1'b0;
    w_pick_b = 1'b0;
    if (lock_q && bus.lock_a) begin
      // A owns the port: B is starved until lock_a drops
      w_grant = bus.req_a;
    end else if (bus.req_a && bus.req_b) begin
      w_grant  = 1'b1;
      w_pick_b = ~last_b_q;
    end else if (bus.req_a) begin
      w_grant = 1'b1;
    end else if (bus.req_b) begin
      w_grant  = 1'b1;
      w_pick_b = 1'b1;
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    win_b_d   = win_b_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_b_d  = last_b_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.lock_a) begin
          lock_d = 1'b0;
        end
        if (w_grant) begin
          win_b_d  = w_pick_b;
          last_b_d = w_pick_b;
          rw_d     = w_pick_b ? bus.rw_b    : bus.rw_a;
          addr_d   = w_pick_b ? bus.addr_b  : bus.addr_a;
          wdata_d  = w_pick_b ? bus.wdata_b : bus.wdata_a;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rw_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = c_rd_lat;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - c_cnt_one;
        // Counter at 1 marks the cycle in which ram_rdata is valid
        if (cnt_q == c_cnt_one) begin
          if (win_b_q) begin
            rdata_b_d = bus.ram_rdata;
          end else begin
            rdata_a_d = bus.ram_rdata;
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        lock_d  = ~win_b_q & bus.lock_a;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      win_b_q   <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_b_q  <= 1'b1;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      win_b_q   <= win_b_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_b_q  <= last_b_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // RAM port and acks decoded from state, so reset zeroes them immediately
  always_comb begin
    bus.ram_address  = '0;
    bus.ram_raddress = '0;
    bus.ram_wdata    = '0;
    bus.ram_we       = 1'b0;
    bus.ram_re       = 1'b0;
    bus.ram_oe       = 1'b0;
    bus.ack_a        = 1'b0;
    bus.ack_b        = 1'b0;
    case (state_q)
      S_ISSUE: begin
        if (rw_q) begin
          bus.ram_address = addr_q;
          bus.ram_wdata   = wdata_q;
          bus.ram_we      = 1'b1;
        end else begin
          bus.ram_raddress = addr_q;
          bus.ram_re       = 1'b1;
          bus.ram_oe       = 1'b1;
        end
      end
      S_WAIT: begin
        bus.ram_raddress = addr_q;
        bus.ram_re       = 1'b1;
        bus.ram_oe       = 1'b1;
      end
      S_ACK: begin
        bus.ack_a = ~win_b_q;
        bus.ack_b = win_b_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;

endmodule
`default_nettype wire
